// File: rtl/prog_loader.sv
// prog_loader: packs a low-byte-first byte stream into 16-bit words and
// writes them to program memory while holding the CPU in reset.
// Ports: clk, rstz (async, active-low); start/abort/base/len load control;
//        byte_in/byte_valid/byte_ready stream; pg/pg_addr/pg_instr write
//        port; cpu_rstz CPU hold; busy/done/err status.
module prog_loader #(
    parameter int MAX_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] base,
    input  logic [11:0] len,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] pg_instr,
    output logic [15:0] pg_addr,
    output logic        pg,
    output logic        cpu_rstz,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, LO, HI, WRITE, DONE
    } state_t;

    state_t      state, state_d;
    logic [15:0] base_q;
    logic [11:0] len_q;
    logic [11:0] idx_q;
    logic [7:0]  lo_q;
    logic        start_bad;
    logic        xfer;
    logic        last_word;

    assign start_bad = base[0] | ({1'b0, len} > 13'(MAX_WORDS));
    assign xfer      = byte_valid & byte_ready;
    assign last_word = (idx_q == len_q - 12'd1);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start && !start_bad) begin
                    if (len == '0) state_d = DONE;
                    else           state_d = LO;
                end
            end
            LO: begin
                if (abort)     state_d = IDLE;
                else if (xfer) state_d = HI;
            end
            HI: begin
                if (abort)     state_d = IDLE;
                else if (xfer) state_d = WRITE;
            end
            WRITE: begin
                if (abort)          state_d = IDLE;
                else if (last_word) state_d = DONE;
                else                state_d = LO;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        pg         = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            LO:      byte_ready = 1'b1;
            HI:      byte_ready = 1'b1;
            WRITE:   pg         = 1'b1;
            DONE:    done       = 1'b1;
            default: ;
        endcase
    end

    // The write word/address are captured on the high-byte transfer so
    // they are valid during WRITE and simply hold afterwards.  Gating on
    // state_d keeps an aborted half-word from disturbing them.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            lo_q     <= '0;
            pg_instr <= '0;
            pg_addr  <= '0;
            err      <= 1'b0;
            cpu_rstz <= 1'b0;
        end else begin
            err      <= (state == IDLE) & start & start_bad;
            // Registered from next state: low for the whole load, and
            // released on the first edge after reset or after DONE.
            cpu_rstz <= (state_d == IDLE);
            if (state == IDLE && state_d == LO) begin
                base_q <= base;
                len_q  <= len;
                idx_q  <= '0;
            end
            if (state == LO && xfer) lo_q <= byte_in;
            if (state == HI && state_d == WRITE) begin
                pg_instr <= {byte_in, lo_q};
                pg_addr  <= base_q + {3'b000, idx_q, 1'b0};
            end
            if (state == WRITE && state_d == LO) idx_q <= idx_q + 12'd1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader.
// Expected writes come from a word-list model built from the byte stream.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rstz;
    logic        start;
    logic        abort;
    logic [15:0] base;
    logic [11:0] len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] pg_instr;
    logic [15:0] pg_addr;
    logic        pg;
    logic        cpu_rstz;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  byte_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          done_cnt;
    int          err_cnt;

    prog_loader #(.MAX_WORDS(2048)) dut (
        .clk(clk), .rstz(rstz), .start(start), .abort(abort),
        .base(base), .len(len), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .pg_instr(pg_instr), .pg_addr(pg_addr), .pg(pg),
        .cpu_rstz(cpu_rstz), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pg === 1'b1)   obs_q.push_back({pg_addr, pg_instr});
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1)  err_cnt++;
    end

    // Model: word w lands at (base + 2w) mod 2^16 as {byte 2w+1, byte 2w}.
    task automatic build_expected(input logic [15:0] b, input int nw);
        exp_q.delete();
        for (int w = 0; w < nw; w++)
            exp_q.push_back({16'(int'(b) + 2 * w), byte_q[2*w+1], byte_q[2*w]});
    endtask

    task automatic gen_bytes(input int n);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
    endtask

    task automatic clear_obs();
        obs_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [11:0] l);
        @(negedge clk);
        start = 1'b1;
        base  = b;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns on the negedge after the last byte has been taken.
    task automatic send_bytes(input int first, input int count, input bit rnd);
        int k;
        int n;
        k = first;
        n = 0;
        while (k < first + count && n < 50 * count + 50) begin
            @(negedge clk);
            byte_in    = byte_q[k];
            byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (byte_valid && byte_ready === 1'b1) k++;
            n++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (k != first + count) begin
            errors++;
            $display("FAIL send_bytes: sent %0d want %0d", k - first, count);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_timeout: busy=%b want 0", nm, busy);
        end
    endtask

    task automatic test_reset();
        rstz = 1'b0;
        #2;
        checks++;
        if ({pg, pg_instr, pg_addr, byte_ready, busy, done, err, cpu_rstz}
            !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs: pg=%b ins=%h adr=%h rdy=%b bsy=%b dn=%b er=%b cr=%b want all 0",
                     pg, pg_instr, pg_addr, byte_ready, busy, done, err, cpu_rstz);
        end
        repeat (2) @(negedge clk);
        rstz = 1'b1;
        #1;
        checks++;
        if (cpu_rstz !== 1'b0) begin
            errors++;
            $display("FAIL reset_cpu_hold: cpu_rstz=%b want 0", cpu_rstz);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cpu_rstz !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: cpu_rstz=%b want 1", cpu_rstz);
        end
    endtask

    task automatic test_two_word();
        clear_obs();
        byte_q = '{8'h34, 8'h12, 8'h78, 8'h56};
        build_expected(16'h0000, 2);
        do_start(16'h0000, 12'd2);
        checks++;
        if (cpu_rstz !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL two_word hold: cpu_rstz=%b busy=%b want 0 1", cpu_rstz, busy);
        end
        send_bytes(0, 2, 1'b0);
        checks++;
        if (pg !== 1'b1 || pg_addr !== 16'h0000 || pg_instr !== 16'h1234) begin
            errors++;
            $display("FAIL two_word latency: pg=%b adr=%h ins=%h want 1 0000 1234",
                     pg, pg_addr, pg_instr);
        end
        send_bytes(2, 2, 1'b0);
        wait_idle("two_word");
        checks++;
        if (cpu_rstz !== 1'b1 || done_cnt != 1) begin
            errors++;
            $display("FAIL two_word end: cpu_rstz=%b done=%0d want 1 1", cpu_rstz, done_cnt);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL two_word count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL two_word write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_loads(input string nm, input int iters, input bit wrap);
        logic [15:0] b;
        int          nw;
        for (int it = 0; it < iters; it++) begin
            clear_obs();
            b  = wrap ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
            nw = wrap ? 2 : $urandom_range(1, 6);
            if (!wrap && it == 0) b = 16'hFFFA;
            gen_bytes(2 * nw);
            build_expected(b, nw);
            do_start(b, 12'(nw));
            send_bytes(0, 2 * nw, 1'b1);
            wait_idle(nm);
            checks++;
            if (done_cnt != 1 || err_cnt != 0) begin
                errors++;
                $display("FAIL %s status%0d: done=%0d err=%0d want 1 0", nm, it, done_cnt, err_cnt);
            end
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL %s count%0d: got %0d want %0d", nm, it, obs_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s write%0d.%0d: got %h want %h", nm, it, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_rejects();
        clear_obs();
        do_start(16'h0010, 12'd0);
        checks++;
        if (done !== 1'b1 || pg !== 1'b0) begin
            errors++;
            $display("FAIL len0 done: done=%b pg=%b want 1 0", done, pg);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cpu_rstz !== 1'b1 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL len0 after: done=%b busy=%b cpu_rstz=%b writes=%0d want 0 0 1 0",
                     done, busy, cpu_rstz, obs_q.size());
        end
        for (int t = 0; t < 2; t++) begin
            if (t == 0) do_start(16'h0001, 12'd4);
            else        do_start(16'h0000, 12'd2049);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || cpu_rstz !== 1'b1) begin
                errors++;
                $display("FAIL reject%0d pulse: err=%b busy=%b cpu_rstz=%b want 1 0 1",
                         t, err, busy, cpu_rstz);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reject%0d after: err=%b busy=%b want 0 0", t, err, busy);
            end
        end
        do_start(16'h0200, 12'd2048);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || cpu_rstz !== 1'b0) begin
            errors++;
            $display("FAIL max_len accept: busy=%b err=%b cpu_rstz=%b want 1 0 0",
                     busy, err, cpu_rstz);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || err_cnt != 2) begin
            errors++;
            $display("FAIL max_len abort: busy=%b errs=%0d want 0 2", busy, err_cnt);
        end
    endtask

    task automatic test_abort(input bit in_write);
        clear_obs();
        gen_bytes(16);
        build_expected(in_write ? 16'h0400 : 16'h0300, 2);
        do_start(in_write ? 16'h0400 : 16'h0300, 12'd8);
        send_bytes(0, in_write ? 4 : 5, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cpu_rstz !== 1'b1) begin
            errors++;
            $display("FAIL abort%0d idle: busy=%b cpu_rstz=%b want 0 1", in_write, busy, cpu_rstz);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 0 || obs_q.size() != 2) begin
            errors++;
            $display("FAIL abort%0d counts: done=%0d writes=%0d want 0 2",
                     in_write, done_cnt, obs_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort%0d write%0d: got %h want %h", in_write, i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({pg_addr, pg_instr} !== exp_q[1]) begin
            errors++;
            $display("FAIL abort%0d hold: got %h want %h", in_write, {pg_addr, pg_instr}, exp_q[1]);
        end
    endtask

    task automatic test_reset_mid_load();
        clear_obs();
        gen_bytes(6);
        do_start(16'h0800, 12'd3);
        send_bytes(0, 1, 1'b0);
        #2;
        rstz = 1'b0;
        #1;
        checks++;
        if ({pg, pg_instr, pg_addr, byte_ready, busy, done, err, cpu_rstz}
            !== 40'd0) begin
            errors++;
            $display("FAIL midreset outputs: pg=%b ins=%h adr=%h rdy=%b bsy=%b dn=%b er=%b cr=%b want all 0",
                     pg, pg_instr, pg_addr, byte_ready, busy, done, err, cpu_rstz);
        end
        @(negedge clk);
        rstz = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cpu_rstz !== 1'b1) begin
            errors++;
            $display("FAIL midreset release: cpu_rstz=%b want 1", cpu_rstz);
        end
        clear_obs();
        gen_bytes(4);
        build_expected(16'h0100, 2);
        do_start(16'h0100, 12'd2);
        send_bytes(0, 4, 1'b1);
        wait_idle("midreset");
        checks++;
        if (done_cnt != 1 || obs_q.size() != 2) begin
            errors++;
            $display("FAIL midreset reload: done=%0d writes=%0d want 1 2", done_cnt, obs_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        clear_obs();
        gen_bytes(4);
        build_expected(16'h0040, 2);
        do_start(16'h0040, 12'd2);
        send_bytes(0, 1, 1'b0);
        start = 1'b1;
        base  = 16'h0001;
        len   = 12'd5;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1 || cpu_rstz !== 1'b0) begin
            errors++;
            $display("FAIL busy_start state: err=%b busy=%b rdy=%b cpu_rstz=%b want 0 1 1 0",
                     err, busy, byte_ready, cpu_rstz);
        end
        send_bytes(1, 3, 1'b0);
        wait_idle("busy_start");
        checks++;
        if (done_cnt != 1 || err_cnt != 0 || obs_q.size() != 2) begin
            errors++;
            $display("FAIL busy_start counts: done=%0d err=%0d writes=%0d want 1 0 2",
                     done_cnt, err_cnt, obs_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL busy_start write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        start      = 1'b0;
        abort      = 1'b0;
        base       = '0;
        len        = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        done_cnt   = 0;
        err_cnt    = 0;
        test_reset();
        test_two_word();
        test_random_loads("wrap", 3, 1'b1);
        test_random_loads("random", 12, 1'b0);
        test_rejects();
        test_abort(1'b0);
        test_abort(1'b1);
        test_reset_mid_load();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
